rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_pkg.sv | 17 +
 rtl/rf_write_arbiter_rr.sv | 48 ++++
 rtl/rf_write_arbiter.sv | 87 ++++++++
 tb/tb_rf_write_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared processor constants for register-file writeback arbitration.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: R15 index (PC-sourced, never written through this path), drop
// counter ceiling, and the one-bit grant encoding used by the round-robin state.
package rf_write_arbiter_pkg;

  localparam logic [3:0] R15_IDX  = 4'd15;
  localparam logic [7:0] DROP_MAX = 8'd255;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/rf_write_arbiter_rr.sv
// Two-requester round-robin grant logic with a 1-bit last-grant memory.
// Latency: grants are combinational from the requests in the same cycle.
// Backpressure: the loser of a contested cycle simply sees no grant and holds.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_a_i, req_b_i     request (valid) from each requester
//   gnt_a_o, gnt_b_o     one-hot-or-zero grant; both 0 while in reset
module rr_arbiter_2
  import rf_write_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  grant_e last_q, last_d;

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    last_d  = last_q;
    if (rst_ni) begin
      if (req_a_i && req_b_i) begin
        if (last_q == GRANT_B) gnt_a_o = 1'b1;
        else                   gnt_b_o = 1'b1;
      end else if (req_a_i) begin
        gnt_a_o = 1'b1;
      end else if (req_b_i) begin
        gnt_b_o = 1'b1;
      end
      // A grant is only ever given to a valid requester, so a grant is a
      // completed transfer; idle cycles leave the history untouched.
      if (gnt_a_o)      last_d = GRANT_A;
      else if (gnt_b_o) last_d = GRANT_B;
    end
  end

  // Reset to GRANT_B so that A wins the first contested cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_q <= GRANT_B;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto a single register-file write port.
// Latency: accepted write appears on the registered outputs 1 cycle after acceptance.
// Backpressure: valid/ready; ready is combinational, the loser holds its request.
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   a_valid/a_dest/a_data/a_ready    ALU writeback request channel
//   b_valid/b_dest/b_data/b_ready    load writeback request channel
//   write_enable                     registered 1-cycle write strobe
//   Destination_select, DATA         registered write index/data (hold when idle)
//   drop_count                       saturating count of writes aimed at R15
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [3:0]       a_dest,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [3:0]       b_dest,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             write_enable,
  output logic [3:0]       Destination_select,
  output logic [WIDTH-1:0] DATA,
  output logic [7:0]       drop_count
);

  logic             we_q, we_d;
  logic [3:0]       dest_q, dest_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       drop_q, drop_d;

  logic             a_xfer, b_xfer, accepted, is_r15;
  logic [3:0]       sel_dest;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter_2 u_rr (
    .clk_i   (clk),
    .rst_ni  (reset),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .gnt_a_o (a_ready),
    .gnt_b_o (b_ready)
  );

  always_comb begin
    a_xfer   = a_valid && a_ready;
    b_xfer   = b_valid && b_ready;
    accepted = a_xfer || b_xfer;
    sel_dest = a_xfer ? a_dest : b_dest;
    sel_data = a_xfer ? a_data : b_data;
    is_r15   = (sel_dest == R15_IDX);

    // R15 writes are accepted (so the requester is released) but discarded;
    // index/data registers keep the last real write.
    we_d   = accepted && !is_r15;
    dest_d = we_d ? sel_dest : dest_q;
    data_d = we_d ? sel_data : data_q;
    drop_d = drop_q;
    if (accepted && is_r15 && (drop_q != DROP_MAX)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q   <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      we_q   <= we_d;
      dest_q <= dest_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

  assign write_enable       = we_q;
  assign Destination_select = dest_q;
  assign DATA               = data_q;
  assign drop_count         = drop_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, b_valid;
  logic [3:0]   a_dest, b_dest;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready;
  logic         write_enable;
  logic [3:0]   Destination_select;
  logic [W-1:0] DATA;
  logic [7:0]   drop_count;

  rf_write_arbiter #(.WIDTH(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .a_valid            (a_valid),
    .a_dest             (a_dest),
    .a_data             (a_data),
    .a_ready            (a_ready),
    .b_valid            (b_valid),
    .b_dest             (b_dest),
    .b_data             (b_data),
    .b_ready            (b_ready),
    .write_enable       (write_enable),
    .Destination_select (Destination_select),
    .DATA               (DATA),
    .drop_count         (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [3:0]   dest;
    logic [W-1:0] data;
    logic         chk_dd;
    logic [7:0]   drop;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Bench-side expectations for held outputs and the drop counter.
  logic [3:0]   m_dest;
  logic [W-1:0] m_data;
  int           m_drop;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per driven cycle, checked #3 after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("write_enable", W'(write_enable), W'(e.we));
        check("drop_count", W'(drop_count), W'(e.drop));
        if (e.chk_dd) begin
          check("Destination_select", W'(Destination_select), W'(e.dest));
          check("DATA", DATA, e.data);
        end
      end
    end
  end

  // Called at posedge+1; drives one cycle, checks readies at negedge,
  // pushes the expected registered output, returns at next posedge+1.
  task automatic drive_cycle(input logic av, input logic [3:0] ad, input logic [W-1:0] adt,
                             input logic bv, input logic [3:0] bd, input logic [W-1:0] bdt,
                             input logic era, input logic erb, input string tag);
    exp_t e;
    a_valid = av; a_dest = ad; a_data = adt;
    b_valid = bv; b_dest = bd; b_data = bdt;
    @(negedge clk);
    check({tag, " a_ready"}, W'(a_ready), W'(era));
    check({tag, " b_ready"}, W'(b_ready), W'(erb));
    e.we = 1'b0; e.chk_dd = 1'b1;
    if (era || erb) begin
      if ((era ? ad : bd) == 4'd15) begin
        if (m_drop < 255) m_drop++;
        e.chk_dd = 1'b0;
      end else begin
        e.we   = 1'b1;
        m_dest = era ? ad : bd;
        m_data = era ? adt : bdt;
      end
    end
    e.dest = m_dest;
    e.data = m_data;
    e.drop = 8'(m_drop);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    drive_cycle(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 1'b0, tag);
  endtask

  // Called at posedge+1; holds reset low for n edges with given valids.
  task automatic do_reset(input logic av, input logic bv, input int n);
    reset = 1'b0;
    a_valid = av; a_dest = 4'd1; a_data = 32'h1;
    b_valid = bv; b_dest = 4'd2; b_data = 32'h2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset a_ready", W'(a_ready), '0);
      check("reset b_ready", W'(b_ready), '0);
      @(posedge clk);
      #1;
    end
    check("reset write_enable", W'(write_enable), '0);
    check("reset Destination_select", W'(Destination_select), '0);
    check("reset DATA", DATA, '0);
    check("reset drop_count", W'(drop_count), '0);
    m_dest = '0; m_data = '0; m_drop = 0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    a_valid = 1'b0; a_dest = '0; a_data = '0;
    b_valid = 1'b0; b_dest = '0; b_data = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0, 3);

    // Contested after reset: A, B, A, B with no bubbles.
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2, 1'b1, 1'b0, "rr A");
      drive_cycle(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2, 1'b0, 1'b1, "rr B");
    end
    idle("idle hold");

    // Single A request, then idle, then contest: B wins (last_grant=A kept).
    drive_cycle(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, '0, 1'b1, 1'b0, "solo A");
    idle("idle after A");
    drive_cycle(1'b1, 4'd4, 32'h44, 1'b1, 4'd6, 32'h66, 1'b0, 1'b1, "post-idle B");
    drive_cycle(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, '0, 1'b1, 1'b0, "held A");

    // Make B most recent, then same-dest contest: A then B, later write wins.
    drive_cycle(1'b0, 4'd0, '0, 1'b1, 4'd7, 32'h77, 1'b0, 1'b1, "solo B");
    drive_cycle(1'b1, 4'd5, 32'hA, 1'b1, 4'd5, 32'hB, 1'b1, 1'b0, "same dest A");
    drive_cycle(1'b0, 4'd5, 32'hA, 1'b1, 4'd5, 32'hB, 1'b0, 1'b1, "same dest B");
    idle("idle 2");

    // R15 writes: accepted, never written, counter saturates at 255.
    for (int i = 0; i < 300; i++)
      drive_cycle(1'b0, 4'd0, '0, 1'b1, 4'd15, 32'hFF, 1'b0, 1'b1, "r15 drop");
    idle("idle 3");
    check("drop saturated", W'(drop_count), 32'd255);

    // Reset while both requesters are valid; A wins first afterwards.
    do_reset(1'b1, 1'b1, 2);
    drive_cycle(1'b1, 4'd8, 32'h88, 1'b1, 4'd9, 32'h99, 1'b1, 1'b0, "post-reset A");
    drive_cycle(1'b0, 4'd8, 32'h88, 1'b1, 4'd9, 32'h99, 1'b0, 1'b1, "post-reset B");
    idle("final idle");

    @(posedge clk);
    #5;
    check("scoreboard drained", W'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
